vlg_tick_sched: RTL and testbench

Multi-channel periodic event scheduler driven by an internal 1 us time base. Each channel has a programmable period in microseconds. When a channel's period expires, the block raises a pending request. One shared event output serves all channels through round-robin arbitration with a valid/ready handshake. It sits between the system clock domain logic and the consumers that need periodic triggers (sampling, polling, LED refresh).

---
 rtl/vlg_tick_sched_pkg.sv | 28 ++
 rtl/vlg_us_tick.sv | 35 +++
 rtl/vlg_tick_sched.sv | 127 ++++++++++++
 tb/tb_vlg_tick_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlg_tick_sched_pkg.sv
// Shared constants, types and the round-robin pick helper for the periodic tick scheduler.
package vlg_tick_sched_pkg;

  localparam int unsigned CH_IDX_W     = 2;
  localparam int unsigned CH_NUM       = 4;
  localparam int unsigned PERIOD_W_DEF = 16;

  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] ch;
  } grant_t;

  // Scans ptr+1, ptr+2, ... (mod CH_NUM); descending order leaves the nearest requester as the winner.
  function automatic grant_t rr_pick(input logic [CH_NUM-1:0] req, input logic [CH_IDX_W-1:0] ptr);
    grant_t              g;
    logic [CH_IDX_W-1:0] idx;
    g = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = ptr + CH_IDX_W'(k);
      if (req[idx]) begin
        g.found = 1'b1;
        g.ch    = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/vlg_us_tick.sv
// Free-running divider producing a registered one-cycle pulse every P_DIV clocks (the 1 us time base).
module vlg_us_tick #(
  parameter int unsigned P_DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CNT_W = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    tick_d = (cnt_q == CNT_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/vlg_tick_sched.sv
// Four-channel periodic event scheduler: per-channel us counters, pending/overrun flags and a
// round-robin single-slot output stage with valid/ready handshake.
module vlg_tick_sched
  import vlg_tick_sched_pkg::*;
#(
  parameter int unsigned P_CLK_PERIORD = 20,
  parameter int unsigned P_CH_NUM      = CH_NUM,
  parameter int unsigned P_PERIOD_W    = PERIOD_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_we,
  input  logic [CH_IDX_W-1:0]   i_cfg_ch,
  input  logic [P_PERIOD_W-1:0] i_cfg_period,
  input  logic [P_CH_NUM-1:0]   i_ch_en,
  output logic                  o_evt_valid,
  output logic [CH_IDX_W-1:0]   o_evt_ch,
  input  logic                  i_evt_ready,
  output logic [P_CH_NUM-1:0]   o_overrun,
  input  logic                  i_overrun_clr
);

  localparam int unsigned DIV = 1000 / P_CLK_PERIORD;
  localparam logic [P_PERIOD_W-1:0] PER_ONE = P_PERIOD_W'(1);

  logic r_tick;

  vlg_us_tick #(.P_DIV(DIV)) u_us_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (r_tick)
  );

  logic [P_PERIOD_W-1:0] period_q [P_CH_NUM];
  logic [P_PERIOD_W-1:0] period_d [P_CH_NUM];
  logic [P_PERIOD_W-1:0] cnt_q    [P_CH_NUM];
  logic [P_PERIOD_W-1:0] cnt_d    [P_CH_NUM];

  logic [P_CH_NUM-1:0] pend_q, pend_d;
  logic [P_CH_NUM-1:0] ovr_q, ovr_d, ovr_set;
  logic [P_CH_NUM-1:0] wr_hit, active, expire, grant_1h;

  logic                valid_q, valid_d;
  logic [CH_IDX_W-1:0] ch_q, ch_d;
  logic [CH_IDX_W-1:0] ptr_q, ptr_d;

  grant_t gnt;
  logic   load;

  // Output slot: refill when empty or being accepted; disabled channels never win.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    gnt      = rr_pick(pend_q & i_ch_en, ptr_q);
    load     = (!valid_q || i_evt_ready) && gnt.found;
    grant_1h = '0;
    valid_d  = valid_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    if (load) begin
      grant_1h[gnt.ch] = 1'b1;
      valid_d          = 1'b1;
      ch_d             = gnt.ch;
      ptr_d            = gnt.ch;
    end else if (valid_q && i_evt_ready) begin
      valid_d = 1'b0;
    end
  end

  // A config write beats a coincident tick; an expiry beats the slot load clearing pending.
  always_comb begin
    wr_hit  = '0;
    active  = '0;
    expire  = '0;
    ovr_set = '0;
    pend_d  = '0;
    for (int n = 0; n < P_CH_NUM; n++) begin
      wr_hit[n]   = i_cfg_we && (i_cfg_ch == CH_IDX_W'(n));
      active[n]   = i_ch_en[n] && (period_q[n] != '0);
      period_d[n] = wr_hit[n] ? i_cfg_period : period_q[n];
      cnt_d[n]    = cnt_q[n];
      if (wr_hit[n] || !active[n]) begin
        cnt_d[n] = '0;
      end else if (r_tick) begin
        if (cnt_q[n] == period_q[n] - PER_ONE) begin
          cnt_d[n]  = '0;
          expire[n] = 1'b1;
        end else begin
          cnt_d[n] = cnt_q[n] + PER_ONE;
        end
      end
      ovr_set[n] = expire[n] && pend_q[n] && !grant_1h[n];
      pend_d[n]  = i_ch_en[n] && ((pend_q[n] && !grant_1h[n]) || expire[n]);
    end
    ovr_d = (i_overrun_clr ? '0 : ovr_q) | ovr_set;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the period/counter arrays are small flop banks that must read zero out of reset,
      // so they are reset like any other state rather than treated as an unreset memory.
      for (int n = 0; n < P_CH_NUM; n++) begin
        period_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      pend_q  <= '0;
      ovr_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= CH_IDX_W'(P_CH_NUM - 1);
    end else begin
      for (int n = 0; n < P_CH_NUM; n++) begin
        period_q[n] <= period_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_ch    = ch_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_vlg_tick_sched.sv
// Scoreboard bench for vlg_tick_sched: a tick-count reference model queues expected events,
// a separate monitor pops them on every accepted handshake.
module tb_vlg_tick_sched;

  localparam int CLK_NS = 20;
  localparam int DIV    = 1000 / CLK_NS;
  localparam int NCH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  ch_en = '0;
  logic        evt_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        o_evt_valid;
  logic [1:0]  o_evt_ch;
  logic [3:0]  o_overrun;

  always #(CLK_NS / 2) clk = ~clk;

  vlg_tick_sched dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cfg_we      (cfg_we),
    .i_cfg_ch      (cfg_ch),
    .i_cfg_period  (cfg_period),
    .i_ch_en       (ch_en),
    .o_evt_valid   (o_evt_valid),
    .o_evt_ch      (o_evt_ch),
    .i_evt_ready   (evt_ready),
    .o_overrun     (o_overrun),
    .i_overrun_clr (ovr_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int ch;
    int edge_no;
  } exp_t;

  exp_t     exp_q[$];
  int       edge_no;
  int       m_period[NCH];
  int       m_ticks[NCH];
  bit       m_pend[NCH];
  bit [3:0] m_ov;
  bit       m_valid;
  int       m_last;

  task automatic model_reset();
    edge_no = 0;
    for (int n = 0; n < NCH; n++) begin
      m_period[n] = 0;
      m_ticks[n]  = 0;
      m_pend[n]   = 0;
    end
    m_ov    = '0;
    m_valid = 0;
    m_last  = NCH - 1;
    exp_q.delete();
  endtask

  // Ticks land every DIV edges; a channel expires whenever its tick count since activation
  // is a multiple of its period.
  task automatic model_step();
    bit       tick, accept, found, act;
    int       gch;
    bit [3:0] granted, expd, ov_set;
    edge_no++;
    tick    = (edge_no > 1) && ((edge_no - 1) % DIV == 0);
    accept  = m_valid && evt_ready;
    found   = 0;
    gch     = 0;
    granted = '0;
    expd    = '0;
    ov_set  = '0;
    if (!m_valid || accept) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if (!found && m_pend[c] && ch_en[c]) begin
          found = 1;
          gch   = c;
        end
      end
    end
    if (found) granted[gch] = 1;
    for (int n = 0; n < NCH; n++) begin
      act = ch_en[n] && (m_period[n] != 0);
      if (cfg_we && (int'(cfg_ch) == n)) begin
        m_period[n] = int'(cfg_period);
        m_ticks[n]  = 0;
      end else if (!act) begin
        m_ticks[n] = 0;
      end else if (tick) begin
        m_ticks[n]++;
        if (m_ticks[n] % m_period[n] == 0) expd[n] = 1;
      end
      if (expd[n] && m_pend[n] && !granted[n]) ov_set[n] = 1;
      m_pend[n] = ch_en[n] && ((m_pend[n] && !granted[n]) || expd[n]);
    end
    m_ov = (ovr_clr ? 4'b0 : m_ov) | ov_set;
    if (found) begin
      m_valid = 1;
      m_last  = gch;
      exp_q.push_back('{gch, edge_no});
    end else if (accept) begin
      m_valid = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  bit   prev_valid = 0;
  bit   prev_acc = 0;
  int   pres_edge = 0;
  int   first_evt_edge = -1;
  int   last_evt_edge = -1;
  int   evt_cnt = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        prev_acc   = 0;
      end else begin
        if (o_evt_valid && (!prev_valid || prev_acc)) begin
          pres_edge     = edge_no;
          last_evt_edge = edge_no;
          if (first_evt_edge < 0) first_evt_edge = edge_no;
        end
        if (o_evt_valid && evt_ready) begin
          evt_cnt++;
          if (exp_q.size() == 0) begin
            check("evt_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            check("evt_ch", 32'(o_evt_ch), 32'(mon_e.ch));
            check("evt_edge", 32'(pres_edge), 32'(mon_e.edge_no));
          end
        end
        check("overrun", 32'(o_overrun), 32'(m_ov));
        prev_valid = o_evt_valid;
        prev_acc   = o_evt_valid && evt_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int per);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = 16'(per);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick_cycle();
    while (edge_no % DIV != 0) step();
  endtask

  task automatic drain();
    int budget;
    evt_ready = 1'b1;
    budget    = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      step();
      budget++;
    end
    step(2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w, c0, budget;
    #(CLK_NS * 3 + 5);
    check("rst_valid", 32'(o_evt_valid), 32'd0);
    check("rst_ch", 32'(o_evt_ch), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ch0 period 3 -> events 2 edges after ticks 3, 6, 9
    ch_en     = 4'b0001;
    evt_ready = 1'b1;
    step();
    cfg(0, 3);
    step(10 * DIV);
    check("first_evt_edge", 32'(first_evt_edge), 32'd152);
    drain();

    // 2: all channels period 1 -> bursts 0,1,2,3 per tick
    for (int n = 0; n < NCH; n++) cfg(n, 1);
    ch_en = 4'b1111;
    step(4 * DIV);
    drain();

    // 3: ch1 alone, consumer stalled -> held event, overrun, clear
    ch_en     = 4'b0010;
    evt_ready = 1'b0;
    wait_tick_cycle();
    step(3 * DIV + 5);
    check("stall_valid", 32'(o_evt_valid), 32'd1);
    check("stall_ch", 32'(o_evt_ch), 32'd1);
    check("stall_overrun", 32'(o_overrun), 32'b0010);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("overrun_cleared", 32'(o_overrun), 32'd0);
    drain();

    // 4: ch2 period 5, reprogram to 2 on a tick cycle with counter at 3
    ch_en = 4'b0000;
    cfg(2, 5);
    ch_en = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wait_tick_cycle();
      step();
    end
    wait_tick_cycle();
    w = edge_no;
    cfg(2, 2);
    step(2 * DIV + 10);
    check("reprog_evt_edge", 32'(last_evt_edge), 32'(w + 102));
    drain();

    // 5: ch3 pending while its enable drops -> only the slotted event survives
    ch_en     = 4'b0000;
    cfg(3, 2);
    ch_en     = 4'b1000;
    evt_ready = 1'b0;
    step(4 * DIV + 5);
    c0    = evt_cnt;
    ch_en = 4'b0000;
    step();
    evt_ready = 1'b1;
    step(10);
    check("disabled_evt_count", 32'(evt_cnt - c0), 32'd1);
    ch_en = 4'b1000;
    step(5 * DIV);
    drain();

    // 6: randomized traffic
    for (int n = 0; n < NCH; n++) cfg(n, $urandom_range(1, 4));
    ch_en = 4'(($urandom_range(0, 15)));
    for (int i = 0; i < 6000; i++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      ovr_clr   = ($urandom_range(0, 99) == 0);
      cfg_we    = ($urandom_range(0, 149) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_period = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) ch_en = 4'($urandom_range(0, 15));
      step();
    end
    cfg_we  = 1'b0;
    ovr_clr = 1'b0;
    drain();

    // 7: asynchronous reset mid-stream
    for (int n = 0; n < NCH; n++) cfg(n, 1);
    ch_en     = 4'b1111;
    evt_ready = 1'b0;
    budget    = 0;
    while (!o_evt_valid && budget < 3 * DIV) begin
      step();
      budget++;
    end
    check("valid_before_reset", 32'(o_evt_valid), 32'd1);
    step(2 * DIV + 3);
    check("overrun_before_reset", 32'(o_overrun != 0), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_evt_valid), 32'd0);
    check("async_rst_overrun", 32'(o_overrun), 32'd0);
    check("async_rst_ch", 32'(o_evt_ch), 32'd0);
    step(3);
    @(negedge clk);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    c0        = evt_cnt;
    step(4 * DIV);
    check("no_evt_after_reset", 32'(evt_cnt - c0), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(CLK_NS * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
